decode_stage_hs: RTL and testbench

Parametrised successor to the single-register decode stage. Places a valid/ready handshake and a 2-entry skid buffer between fetch and execute, so backpressure does not combinationally cross the stage. Adds flush, instruction-format classification and illegal-opcode detection. Field extraction and immediate generation operate on the head (output) entry.

---
 rtl/decode_stage_hs_pkg.sv | 17 +
 rtl/decode_imm_gen.sv | 38 +++
 rtl/decode_stage_hs.sv | 101 ++++++++++
 tb/tb_decode_stage_hs.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/decode_stage_hs_pkg.sv
// decode_stage_hs_pkg: opcodes, reset constants and instruction format enum shared by the decode stage
package decode_stage_hs_pkg;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [31:0] INSN_NOP       = 32'h0000_0013;
    localparam logic [31:0] IMEM_BASE_ADDR = 32'h0000_1000;
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE} fmt_e;
endpackage

// File: rtl/decode_imm_gen.sv
// decode_imm_gen: opcode to format/illegal classification and sign-extended immediate
module decode_imm_gen
    import decode_stage_hs_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] insn_i,
    output logic [2:0]        fmt_o,
    output logic              illegal_o,
    output logic [DWIDTH-1:0] imm_o
);
    logic [31:0] w;
    logic [31:0] imm;
    fmt_e        fmt;
    assign w = insn_i[31:0];
    always_comb begin
        case (w[6:0])
            OP_LUI, OP_AUIPC:                           fmt = FMT_U;
            OP_JAL:                                     fmt = FMT_J;
            OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM, OP_FENCE: fmt = FMT_I;
            OP_STORE:                                   fmt = FMT_S;
            OP_BRANCH:                                  fmt = FMT_B;
            OP_OP:                                      fmt = FMT_R;
            default:                                    fmt = FMT_NONE;
        endcase
        case (fmt)
            FMT_I:   imm = {{20{w[31]}}, w[31:20]};
            FMT_S:   imm = {{20{w[31]}}, w[31:25], w[11:7]};
            FMT_B:   imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            FMT_U:   imm = {w[31:12], 12'b0};
            FMT_J:   imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: imm = '0;
        endcase
    end
    assign fmt_o     = fmt;
    assign illegal_o = fmt == FMT_NONE;
    assign imm_o     = DWIDTH'(imm);
endmodule

// File: rtl/decode_stage_hs.sv
// decode_stage_hs: handshaked decode stage with 2-entry skid buffer, flush and format decode
module decode_stage_hs
    import decode_stage_hs_pkg::*;
#(
    parameter int                 DWIDTH   = 32,
    parameter int                 AWIDTH   = 32,
    parameter logic [AWIDTH-1:0]  RESET_PC = AWIDTH'(IMEM_BASE_ADDR),
    parameter bit                 SKID_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DWIDTH-1:0] insn_i,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [2:0]        funct3_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [4:0]        shamt_o,
    output logic [6:0]        funct7_o,
    output logic [DWIDTH-1:0] imm_o,
    output logic [2:0]        fmt_o,
    output logic              illegal_o
);
    logic              head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;
    logic [DWIDTH-1:0] head_insn_q, head_insn_d, skid_insn_q, skid_insn_d;
    logic [AWIDTH-1:0] head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
    logic              accept, consume;
    // with the skid buffer, ready depends only on state so backpressure stays registered
    assign in_ready_o = SKID_EN ? ~skid_valid_q : (~head_valid_q | out_ready_i);
    assign accept     = in_valid_i & in_ready_o;
    assign consume    = head_valid_q & out_ready_i;
    always_comb begin
        head_valid_d = head_valid_q;
        head_insn_d  = head_insn_q;
        head_pc_d    = head_pc_q;
        skid_valid_d = skid_valid_q;
        skid_insn_d  = skid_insn_q;
        skid_pc_d    = skid_pc_q;
        if (flush_i) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (consume) begin
                head_insn_d  = skid_insn_q;
                head_pc_d    = skid_pc_q;
                skid_valid_d = 1'b0;
            end
        end else if (!head_valid_q || consume) begin
            head_valid_d = accept;
            if (accept) begin
                head_insn_d = insn_i;
                head_pc_d   = pc_i;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_insn_d  = insn_i;
            skid_pc_d    = pc_i;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_valid_q <= 1'b0;
            head_insn_q  <= DWIDTH'(INSN_NOP);
            head_pc_q    <= RESET_PC;
            skid_valid_q <= 1'b0;
            skid_insn_q  <= DWIDTH'(INSN_NOP);
            skid_pc_q    <= RESET_PC;
        end else begin
            head_valid_q <= head_valid_d;
            head_insn_q  <= head_insn_d;
            head_pc_q    <= head_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_insn_q  <= skid_insn_d;
            skid_pc_q    <= skid_pc_d;
        end
    end
    assign out_valid_o = head_valid_q;
    assign pc_o        = head_pc_q;
    assign insn_o      = head_insn_q;
    assign opcode_o    = head_insn_q[6:0];
    assign rd_o        = head_insn_q[11:7];
    assign funct3_o    = head_insn_q[14:12];
    assign rs1_o       = head_insn_q[19:15];
    assign rs2_o       = head_insn_q[24:20];
    assign shamt_o     = head_insn_q[24:20];
    assign funct7_o    = head_insn_q[31:25];
    decode_imm_gen #(.DWIDTH(DWIDTH)) u_imm_gen (
        .insn_i    (head_insn_q),
        .fmt_o     (fmt_o),
        .illegal_o (illegal_o),
        .imm_o     (imm_o)
    );
endmodule

// File: tb/tb_decode_stage_hs.sv
// tb_decode_stage_hs: directed and random handshake traffic against a queue-based reference model
module tb_decode_stage_hs;
    import decode_stage_hs_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid_i = 1'b0, in_ready_o;
    logic [31:0] insn_i = '0, pc_i = '0;
    logic        flush_i = 1'b0, out_valid_o, out_ready_i = 1'b0;
    logic [31:0] pc_o, insn_o, imm_o;
    logic [6:0]  opcode_o, funct7_o;
    logic [4:0]  rd_o, rs1_o, rs2_o, shamt_o;
    logic [2:0]  funct3_o, fmt_o;
    logic        illegal_o;
    int          n_checks = 0, n_errors = 0;
    logic [63:0] q[$];
    decode_stage_hs dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .insn_i(insn_i), .pc_i(pc_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o),
        .rd_o(rd_o), .funct3_o(funct3_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .shamt_o(shamt_o), .funct7_o(funct7_o), .imm_o(imm_o), .fmt_o(fmt_o),
        .illegal_o(illegal_o)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [2:0] ref_fmt(input logic [31:0] w);
        case (w & 32'h7f)
            32'h37, 32'h17:                         return FMT_U;
            32'h6f:                                 return FMT_J;
            32'h67, 32'h03, 32'h13, 32'h73, 32'h0f: return FMT_I;
            32'h23:                                 return FMT_S;
            32'h63:                                 return FMT_B;
            32'h33:                                 return FMT_R;
            default:                                return FMT_NONE;
        endcase
    endfunction
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        logic signed [31:0] sw;
        logic [31:0] s20, s19, s11;
        sw  = w;
        s20 = sw >>> 20;
        s19 = sw >>> 19;
        s11 = sw >>> 11;
        case (ref_fmt(w))
            FMT_I:   return s20;
            FMT_S:   return (s20 & ~32'h1f) | ((w >> 7) & 32'h1f);
            FMT_B:   return (s19 & 32'hfffff000) | ((w << 4) & 32'h800) | ((w >> 20) & 32'h7e0) | ((w >> 7) & 32'h1e);
            FMT_U:   return w & 32'hfffff000;
            FMT_J:   return (s11 & 32'hfff00000) | (w & 32'h000ff000) | ((w >> 9) & 32'h800) | ((w >> 20) & 32'h7fe);
            default: return 32'h0;
        endcase
    endfunction
    task automatic compare();
        logic [31:0] w, p;
        check("out_valid", 64'(out_valid_o), 64'(q.size() > 0));
        check("in_ready", 64'(in_ready_o), 64'(q.size() < 2));
        if (q.size() > 0) begin
            {p, w} = q[0];
            check("pc", 64'(pc_o), 64'(p));
            check("insn", 64'(insn_o), 64'(w));
            check("opcode", 64'(opcode_o), 64'(w & 32'h7f));
            check("rd", 64'(rd_o), 64'((w >> 7) % 32));
            check("funct3", 64'(funct3_o), 64'((w >> 12) % 8));
            check("rs1", 64'(rs1_o), 64'((w >> 15) % 32));
            check("rs2", 64'(rs2_o), 64'((w >> 20) % 32));
            check("shamt", 64'(shamt_o), 64'((w >> 20) % 32));
            check("funct7", 64'(funct7_o), 64'(w >> 25));
            check("imm", 64'(imm_o), 64'(ref_imm(w)));
            check("fmt", 64'(fmt_o), 64'(ref_fmt(w)));
            check("illegal", 64'(illegal_o), 64'(ref_fmt(w) == FMT_NONE));
        end
    endtask
    task automatic step(input logic v, input logic [31:0] w, input logic [31:0] p, input logic rdy, input logic fl);
        bit acc, con;
        in_valid_i = v; insn_i = w; pc_i = p; out_ready_i = rdy; flush_i = fl;
        #1 compare();
        acc = v && q.size() < 2;
        con = rdy && q.size() > 0;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back({p, w});
        end
        @(negedge clk);
    endtask
    task automatic check_reset();
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_ready", 64'(in_ready_o), 64'd1);
        check("rst_pc", 64'(pc_o), 64'(IMEM_BASE_ADDR));
        check("rst_insn", 64'(insn_o), 64'h13);
        check("rst_opcode", 64'(opcode_o), 64'h13);
        check("rst_fields", 64'({rd_o, rs1_o, rs2_o, funct3_o, funct7_o, shamt_o}), 64'd0);
        check("rst_imm", 64'(imm_o), 64'd0);
        check("rst_fmt", 64'(fmt_o), 64'(FMT_I));
        check("rst_illegal", 64'(illegal_o), 64'd0);
    endtask
    function automatic logic [31:0] rand_insn();
        logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 10)];
        return w;
    endfunction
    initial begin
        in_valid_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset();
        rst = 1'b1;
        step(0, 0, 0, 1, 0);
        step(1, 32'h00500093, 32'h01000000, 1, 0);
        check("addi_rd", 64'(rd_o), 64'd1);
        check("addi_imm", 64'(imm_o), 64'd5);
        check("addi_fmt", 64'(fmt_o), 64'(FMT_I));
        step(0, 0, 0, 1, 0);
        step(1, 32'hFE000EE3, 32'h01000004, 0, 0);
        step(1, 32'h123450B7, 32'h01000008, 0, 0);
        check("skid_ready", 64'(in_ready_o), 64'd0);
        check("beq_imm", 64'(imm_o), 64'hFFFFFFFC);
        check("beq_fmt", 64'(fmt_o), 64'(FMT_B));
        step(0, 0, 0, 1, 0);
        check("lui_imm", 64'(imm_o), 64'h12345000);
        check("lui_fmt", 64'(fmt_o), 64'(FMT_U));
        step(0, 0, 0, 1, 0);
        step(1, 32'h00100113, 32'h0100000c, 0, 0);
        step(1, 32'h00200193, 32'h01000010, 0, 0);
        step(1, 32'hDEADBEEF, 32'h01000014, 0, 1);
        check("flush_valid", 64'(out_valid_o), 64'd0);
        check("flush_ready", 64'(in_ready_o), 64'd1);
        repeat (3) step(0, 0, 0, 1, 0);
        step(1, 32'hFFFFFFFF, 32'h01000018, 0, 0);
        check("ill_flag", 64'(illegal_o), 64'd1);
        check("ill_fmt", 64'(fmt_o), 64'(FMT_NONE));
        check("ill_imm", 64'(imm_o), 64'd0);
        step(0, 0, 0, 1, 0);
        step(1, 32'h00300213, 32'h0100001c, 0, 0);
        step(1, 32'h00400293, 32'h01000020, 0, 0);
        in_valid_i = 1'b1; rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset();
        rst = 1'b1;
        q.delete();
        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 9) < 6, rand_insn(), $urandom, $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
